alarm_ctrl: RTL and testbench

- Home-security alarm controller: combines a panic button, an arm/enable switch, an exit-in-progress flag and three intrusion sensors (window, door, garage) into a single registered alarm output.
- Captures which sensor zone first tripped the alarm.
- Sits between debounced front-panel/sensor inputs and the siren driver.

---
 rtl/alarm_ctrl_if.sv | 45 ++++
 rtl/alarm_ctrl.sv | 86 ++++++++
 tb/tb_alarm_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// ----------------------------------------------------------------------------
// alarm_ctrl_if
// Bundle of the front-panel/sensor inputs and the siren-side outputs of the
// alarm controller.
//
// Handshake: there is no valid/ready pair here. Every input is a level that
// is sampled on each rising clk edge, and every output is a registered level
// that changes only on a rising edge (or on async reset).
//
// Signals:
//   panic     in   panic button, forces alarm regardless of arming
//   enable    in   system armed when 1; 0 disarms and clears latched state
//   exiting   in   occupant leaving; suppresses intrusion detection
//   window    in   window sensor open
//   door      in   door sensor open
//   garage    in   garage sensor open
//   alarm     out  siren request (registered)
//   trip_zone out  {garage, door, window} snapshot at first trip
//   armed     out  registered (enable & ~exiting)
//   state_dbg out  intrusion latch state (0 = clear, 1 = latched)
// ----------------------------------------------------------------------------
interface alarm_ctrl_if;
    logic       panic;
    logic       enable;
    logic       exiting;
    logic       window;
    logic       door;
    logic       garage;
    logic       alarm;
    logic [2:0] trip_zone;
    logic       armed;
    logic       state_dbg;

    // Driver side (front panel / sensors / testbench).
    modport master (
        output panic, enable, exiting, window, door, garage,
        input  alarm, trip_zone, armed, state_dbg
    );

    // Controller side.
    modport slave (
        input  panic, enable, exiting, window, door, garage,
        output alarm, trip_zone, armed, state_dbg
    );
endinterface

// File: rtl/alarm_ctrl.sv
// ----------------------------------------------------------------------------
// alarm_ctrl
// Home-security alarm controller. Combines panic, arming, exit-delay flag and
// three intrusion sensors into one registered siren request, and records which
// zones were open when the intrusion alarm first tripped.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of alarm_ctrl_if (inputs and registered outputs)
//
// Parameters:
//   LATCH_EN  1: intrusion alarm latches until disarm (enable=0) or reset
//             0: intrusion alarm follows the inputs each cycle
// ----------------------------------------------------------------------------
module alarm_ctrl #(
    parameter bit LATCH_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);

    typedef enum logic {
        ST_CLEAR   = 1'b0,
        ST_LATCHED = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       alarm_q, alarm_d;
    logic [2:0] trip_zone_q, trip_zone_d;
    logic       armed_q, armed_d;

    logic [2:0] zone;
    logic       intrusion;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            alarm_q     <= 1'b0;
            trip_zone_q <= 3'b000;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            trip_zone_q <= trip_zone_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        zone        = {bus.garage, bus.door, bus.window};
        intrusion   = bus.enable & ~bus.exiting & (|zone);
        state_d     = state_q;
        trip_zone_d = trip_zone_q;
        alarm_d     = 1'b0;
        armed_d     = bus.enable & ~bus.exiting;

        if (LATCH_EN) begin
            // Disarm has priority over a new or held intrusion.
            if (!bus.enable) begin
                state_d = ST_CLEAR;
            end else if (intrusion) begin
                state_d = ST_LATCHED;
            end
            // Snapshot only on the clear->latched transition, then hold.
            if (state_d == ST_CLEAR) begin
                trip_zone_d = 3'b000;
            end else if (state_q == ST_CLEAR) begin
                trip_zone_d = zone;
            end
        end else begin
            state_d     = intrusion ? ST_LATCHED : ST_CLEAR;
            trip_zone_d = intrusion ? zone : 3'b000;
        end

        // Panic is never stored in the latch, so it drops as soon as released.
        alarm_d = bus.panic | (state_d == ST_LATCHED);
    end

    assign bus.alarm     = alarm_q;
    assign bus.trip_zone = trip_zone_q;
    assign bus.armed     = armed_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alarm_ctrl_if b_lat ();
    alarm_ctrl_if b_nol ();

    alarm_ctrl #(.LATCH_EN(1'b1)) u_lat (.clk(clk), .rst(rst), .bus(b_lat));
    alarm_ctrl #(.LATCH_EN(1'b0)) u_nol (.clk(clk), .rst(rst), .bus(b_nol));

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_lat(input logic p, input logic en, input logic ex,
                             input logic [2:0] gdw);
        b_lat.panic   = p;
        b_lat.enable  = en;
        b_lat.exiting = ex;
        {b_lat.garage, b_lat.door, b_lat.window} = gdw;
    endtask

    task automatic drive_nol(input logic p, input logic en, input logic ex,
                             input logic [2:0] gdw);
        b_nol.panic   = p;
        b_nol.enable  = en;
        b_nol.exiting = ex;
        {b_nol.garage, b_nol.door, b_nol.window} = gdw;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input logic a, input logic [2:0] tz,
                           input logic arm);
        chk({tag, ".alarm"},     {2'b00, b_lat.alarm}, {2'b00, a});
        chk({tag, ".trip_zone"}, b_lat.trip_zone,      tz);
        chk({tag, ".armed"},     {2'b00, b_lat.armed}, {2'b00, arm});
    endtask

    task automatic chk_nol(input string tag, input logic a, input logic [2:0] tz);
        chk({tag, ".alarm"},     {2'b00, b_nol.alarm}, {2'b00, a});
        chk({tag, ".trip_zone"}, b_nol.trip_zone,      tz);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive_lat(1'b0, 1'b0, 1'b0, 3'b000);
        drive_nol(1'b0, 1'b0, 1'b0, 3'b000);

        #3;
        chk_lat("reset_lat", 1'b0, 3'b000, 1'b0);
        chk_nol("reset_nol", 1'b0, 3'b000);

        step();
        rst = 1'b0;

        // Disarmed: no sensor combination raises the alarm.
        for (int v = 0; v < 8; v++) begin
            drive_lat(1'b0, 1'b0, 1'b0, v[2:0]);
            step();
            chk_lat($sformatf("disarm_sweep_%0d", v), 1'b0, 3'b000, 1'b0);
        end

        // Disarmed and exiting: still nothing.
        for (int v = 0; v < 8; v++) begin
            drive_lat(1'b0, 1'b0, 1'b1, v[2:0]);
            step();
            chk_lat($sformatf("exit_sweep_%0d", v), 1'b0, 3'b000, 1'b0);
        end

        // Panic works while disarmed and is not latched.
        drive_lat(1'b1, 1'b0, 1'b1, 3'b000);
        step();
        chk_lat("panic_on", 1'b1, 3'b000, 1'b0);
        drive_lat(1'b0, 1'b0, 1'b1, 3'b000);
        step();
        chk_lat("panic_off", 1'b0, 3'b000, 1'b0);

        // Door intrusion latches and snapshots zone 010.
        drive_lat(1'b0, 1'b1, 1'b0, 3'b010);
        step();
        chk_lat("door_trip", 1'b1, 3'b010, 1'b1);
        // Later window opening does not alter the snapshot.
        drive_lat(1'b0, 1'b1, 1'b0, 3'b011);
        step();
        chk_lat("snapshot_hold", 1'b1, 3'b010, 1'b1);
        // Closing sensors and exiting does not clear a latched alarm.
        drive_lat(1'b0, 1'b1, 1'b1, 3'b000);
        step();
        chk_lat("latched_exit", 1'b1, 3'b010, 1'b0);
        // Disarm clears.
        drive_lat(1'b0, 1'b0, 1'b1, 3'b000);
        step();
        chk_lat("disarm_clear", 1'b0, 3'b000, 1'b0);

        // Panic together with disarm: alarm stays, latch still clears.
        drive_lat(1'b0, 1'b1, 1'b0, 3'b001);
        step();
        chk_lat("window_trip", 1'b1, 3'b001, 1'b1);
        drive_lat(1'b1, 1'b0, 1'b0, 3'b000);
        step();
        chk_lat("panic_and_disarm", 1'b1, 3'b000, 1'b0);
        chk("panic_and_disarm.state", {2'b00, b_lat.state_dbg}, 3'b000);
        drive_lat(1'b0, 1'b1, 1'b0, 3'b000);
        step();
        chk_lat("latch_was_cleared", 1'b0, 3'b000, 1'b1);

        // Exiting masks all sensors; dropping exiting trips with 111.
        drive_lat(1'b0, 1'b1, 1'b1, 3'b111);
        step();
        chk_lat("exit_mask", 1'b0, 3'b000, 1'b0);
        drive_lat(1'b0, 1'b1, 1'b0, 3'b111);
        step();
        chk_lat("all_trip", 1'b1, 3'b111, 1'b1);
        drive_lat(1'b0, 1'b1, 1'b0, 3'b000);
        step();
        chk_lat("all_trip_held", 1'b1, 3'b111, 1'b1);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk_lat("async_rst", 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        step();
        chk_lat("after_rst", 1'b0, 3'b000, 1'b1);

        // Non-latching build: one-cycle garage pulse.
        drive_nol(1'b0, 1'b1, 1'b0, 3'b100);
        step();
        chk_nol("nol_garage", 1'b1, 3'b100);
        drive_nol(1'b0, 1'b1, 1'b0, 3'b000);
        step();
        chk_nol("nol_release", 1'b0, 3'b000);
        // Zone follows inputs each cycle while intrusion persists.
        drive_nol(1'b0, 1'b1, 1'b0, 3'b010);
        step();
        chk_nol("nol_door", 1'b1, 3'b010);
        drive_nol(1'b0, 1'b1, 1'b0, 3'b001);
        step();
        chk_nol("nol_window", 1'b1, 3'b001);
        drive_nol(1'b0, 1'b1, 1'b1, 3'b111);
        step();
        chk_nol("nol_exit", 1'b0, 3'b000);
        drive_nol(1'b1, 1'b1, 1'b1, 3'b000);
        step();
        chk_nol("nol_panic", 1'b1, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
